timer_irq_controller: RTL
=========================

# timer_irq_controller

Interrupt controller for the four-timer bank: captures rising edges of the per-timer interrupt lines, holds them as pending, and applies a mask. It arbitrates the enabled pending sources round-robin and presents a single `irq` to the CPU. The CPU acknowledges through an Avalon-style register port (`read_n`/`write_n`, active-low) by reading a vector register and completes service by writing EOI. It sits between the timer bank's `interrupts` outputs and the CPU interrupt input.

## Interface
- NUM_SRC, 4, number of interrupt sources; supported range 2..4. ID width is 2.
- DATA_W, 32, register data width.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- read_n  in  1  active-low read strobe, single cycle.
- write_n  in  1  active-low write strobe, single cycle.
- address  in  32  byte address; `address[3:2]` selects the register; `address[31:4]` must be 0, otherwise the access is ignored.
- writeData  in  DATA_W  write data.
- readData  out  DATA_W  registered read data.
- src_irq  in  NUM_SRC  timer interrupt lines; bit i comes from timer i.
- irq  out  1  registered interrupt request to the CPU.

## Operation
- Registers:
  - 0x0 STATUS (R/W1C):
    - read: `[3:0]` pending, `[7:4]` in-service one-hot, `[9:8]` state (0 IDLE, 1 ASSERT, 2 SERVICE).
    - write: 1s in `[3:0]` clear the matching pending bits.
  - 0x4 MASK (R/W): `[3:0]` per-source enable; reset value 0.
  - 0x8 VECTOR (R): `[31]` valid, `[1:0]` source id.
  - 0xC EOI (W): the data value is ignored.
- Edge capture:
  - `prev` is registered from `src_irq` and resets to 0.
  - A rising edge, `src_irq[i] & ~prev[i]`, sets `pending[i]`. A line already high when reset is released therefore counts as an edge.
  - An edge and a W1C of the same bit in the same cycle: set wins.
- Eligible set: `pending & mask`.
- Round-robin arbitration:
  - Pointer `ptr` resets to 0.
  - The winner is the first eligible index found searching `ptr, ptr+1, …`, wrapping modulo NUM_SRC.
- FSM:
  - IDLE:
    - If eligible is non-zero: latch winner into `cur_id`, go to ASSERT.
    - Otherwise stay in IDLE.
  - ASSERT (`irq`=1):
    - VECTOR read: returns `{1, cur_id}`, clears `pending[cur_id]`, sets `in_service[cur_id]`, sets `ptr = cur_id+1 mod NUM_SRC`, goes to SERVICE.
    - `pending[cur_id] & mask[cur_id]` drops to 0 (via W1C or mask write) with no VECTOR read in the same cycle: go to IDLE (withdraw); `ptr` is unchanged.
  - SERVICE (`irq`=0):
    - EOI write clears `in_service` and goes to IDLE.
    - New edges on any source, including `cur_id`, set pending normally.
- VECTOR read outside ASSERT returns 0 and has no side effect.
- EOI write outside SERVICE is ignored.
- Read and write in the same cycle: the write takes effect and the read returns pre-write register contents. A VECTOR read cannot be paired with an EOI write because they use different addresses.
- Accesses with `address[31:4]` non-zero: reads return 0, writes have no effect.

## Timing
- Reset values:
  - `irq`=0, `readData`=0.
  - pending, mask, in_service, `prev`, `ptr` all 0.
  - State IDLE.
- Reset mid-operation (any state) clears everything in the same cycle; no interrupt is retained.
- Edge latency:
  - Edge sampled in cycle N: pending visible in STATUS reads issued from N+1.
  - If the source is enabled and the FSM is IDLE: ASSERT and `irq`=1 from cycle N+2.
- Read latency:
  - `read_n` low in cycle N: `readData` valid in cycle N+1.
  - `readData` is 0 in any cycle with no read in the previous cycle.
- `irq` falls one cycle after the VECTOR-read cycle or the withdraw cycle.
- After EOI in cycle N: IDLE in N+1; if eligible is non-zero, `irq` rises again at N+2.
- `irq` is low for at least one cycle between consecutive interrupts.

## Test plan
- Reset, MASK=0xF, pulse `src_irq[2]` at cycle 10:
  - `irq`=1 at cycle 12.
  - VECTOR read returns 0x8000_0002; `irq`=0 the next cycle.
  - STATUS reads `[7:4]`=0x4, `[1:0]`... pending=0.
  - EOI returns state to IDLE.
- Edges on sources 0, 1 and 3 in the same cycle, MASK=0xF: three acknowledge/EOI rounds yield ids 0, 1, 3. Then new edges on 0 and 3 yield 0, then 3 (ptr=1 after id 0).
- MASK=0, pulse `src_irq[1]`:
  - `irq` stays 0 and STATUS pending=0x2.
  - Write MASK=0x2: `irq`=1 two cycles later.
- In ASSERT for id 1, write STATUS=0x2: `irq` drops, FSM returns to IDLE, ptr is unchanged, and a VECTOR read afterwards returns 0.
- In SERVICE for id 0, pulse `src_irq[0]`: pending[0] sets. After EOI, `irq` reasserts at EOI+2 with VECTOR id 0.
- Assert `rst` while in SERVICE with pending=0xA: next cycle all registers read 0 and `irq`=0. A read to address 0x10 returns 0.

Source files
------------

// File: rtl/timer_irq_controller_if.sv
// Avalon-style register port between the CPU (master) and the timer
// interrupt controller (slave). Strobes are active-low, single cycle.
interface timer_irq_controller_if #(
    parameter int DATA_W = 32
);
    logic              read_n;
    logic              write_n;
    logic [31:0]       address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;

    modport master (
        output read_n,
        output write_n,
        output address,
        output writeData,
        input  readData
    );

    modport slave (
        input  read_n,
        input  write_n,
        input  address,
        input  writeData,
        output readData
    );
endinterface

// File: rtl/timer_irq_controller.sv
// Interrupt controller for the four-timer bank: rising-edge capture into
// pending bits, per-source mask, round-robin arbitration and a three-state
// ASSERT/SERVICE handshake with the CPU through a small register file.
module timer_irq_controller #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    timer_irq_controller_if.slave  bus,
    input  logic [NUM_SRC-1:0]     src_irq,
    output logic                   irq
);
    localparam int ID_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [NUM_SRC-1:0]  prev_reg;
    logic [NUM_SRC-1:0]  pending_reg;
    logic [NUM_SRC-1:0]  mask_reg;
    logic [NUM_SRC-1:0]  in_service_reg;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     cur_id_reg;
    logic                irq_reg;
    logic [DATA_W-1:0]   read_data_reg;

    logic                addr_ok;
    logic                rd;
    logic                wr;
    logic [1:0]          sel;
    logic [NUM_SRC-1:0]  edge_det;
    logic [NUM_SRC-1:0]  w1c;
    logic [NUM_SRC-1:0]  cur_onehot;
    logic [NUM_SRC-1:0]  pending_next;
    logic [NUM_SRC-1:0]  mask_next;
    logic [NUM_SRC-1:0]  eligible;
    logic                vec_ack;
    logic                eoi;
    logic                win_found;
    logic [ID_W-1:0]     win_id;
    logic [ID_W-1:0]     ptr_after;
    logic [3:0]          pend_ext;
    logic [3:0]          svc_ext;
    logic [3:0]          mask_ext;
    logic [DATA_W-1:0]   read_data_next;
    logic                unused_bits;

    // Upper write-data bits and the byte lane of the address carry no meaning.
    assign unused_bits = ^{bus.writeData[DATA_W-1:NUM_SRC], bus.address[1:0]};

    // Bus decode: anything outside the 16-byte window is silently dropped.
    assign addr_ok = (bus.address[31:4] == 28'd0);
    assign rd      = ~bus.read_n  & addr_ok;
    assign wr      = ~bus.write_n & addr_ok;
    assign sel     = bus.address[3:2];

    assign w1c       = (wr && sel == 2'd0) ? bus.writeData[NUM_SRC-1:0] : '0;
    assign mask_next = (wr && sel == 2'd1) ? bus.writeData[NUM_SRC-1:0] : mask_reg;
    assign vec_ack   = rd && (sel == 2'd2) && (state_reg == ST_ASSERT);
    assign eoi       = wr && (sel == 2'd3) && (state_reg == ST_SERVICE);
    assign eligible  = pending_reg & mask_reg;
    assign ptr_after = (cur_id_reg == ID_W'(NUM_SRC - 1)) ? '0 : cur_id_reg + 1'b1;

    // Per-source edge capture; a fresh edge beats any clear in the same cycle.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign edge_det[gi]     = src_irq[gi] & ~prev_reg[gi];
            assign cur_onehot[gi]   = (cur_id_reg == ID_W'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~w1c[gi]
                                       & ~(vec_ack & cur_onehot[gi])) | edge_det[gi];
        end
    endgenerate

    // Round-robin search starting at ptr and wrapping modulo NUM_SRC.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int off = 0; off < NUM_SRC; off++) begin
            idx = (int'(ptr_reg) + off) % NUM_SRC;
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // Read mux built from pre-write register contents.
    always_comb begin
        pend_ext = '0;
        svc_ext  = '0;
        mask_ext = '0;
        pend_ext[NUM_SRC-1:0] = pending_reg;
        svc_ext[NUM_SRC-1:0]  = in_service_reg;
        mask_ext[NUM_SRC-1:0] = mask_reg;
        read_data_next = '0;
        if (rd) begin
            case (sel)
                2'd0: begin
                    read_data_next[3:0] = pend_ext;
                    read_data_next[7:4] = svc_ext;
                    read_data_next[9:8] = state_reg;
                end
                2'd1: read_data_next[3:0] = mask_ext;
                2'd2: begin
                    if (state_reg == ST_ASSERT) begin
                        read_data_next[DATA_W-1] = 1'b1;
                        read_data_next[ID_W-1:0] = cur_id_reg;
                    end
                end
                default: read_data_next = '0;
            endcase
        end
    end

    // All state, including the handshake FSM and its registered irq output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            prev_reg       <= '0;
            pending_reg    <= '0;
            mask_reg       <= '0;
            in_service_reg <= '0;
            ptr_reg        <= '0;
            cur_id_reg     <= '0;
            irq_reg        <= 1'b0;
            read_data_reg  <= '0;
        end else begin
            prev_reg      <= src_irq;
            pending_reg   <= pending_next;
            mask_reg      <= mask_next;
            read_data_reg <= read_data_next;
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        cur_id_reg <= win_id;
                        state_reg  <= ST_ASSERT;
                        irq_reg    <= 1'b1;
                    end else begin
                        irq_reg    <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (vec_ack) begin
                        in_service_reg <= cur_onehot;
                        ptr_reg        <= ptr_after;
                        state_reg      <= ST_SERVICE;
                        irq_reg        <= 1'b0;
                    end else if ((cur_onehot & pending_next & mask_next) == '0) begin
                        // Source withdrawn before acknowledge; ptr stays put.
                        state_reg <= ST_IDLE;
                        irq_reg   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    irq_reg <= 1'b0;
                    if (eoi) begin
                        in_service_reg <= '0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    irq_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.readData = read_data_reg;
    assign irq          = irq_reg;
endmodule
